// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-to-8 decoder through masked lines with a programmable dwell.
// Define SCAN_SEQ_BLANK_EN to insert a one-cycle en=0 gap before every line.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a2,
  output logic               a1,
  output logic               a0,
  output logic               en,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
`ifdef SCAN_SEQ_BLANK_EN
  localparam state_t FIRST = BLANK;
`else
  localparam state_t FIRST = DRIVE;
`endif
  state_t state, state_d;
  logic [2:0] addr, addr_d, nxt_idx, low_in, low_l;
  logic nxt_ok, cont_l, en_d, busy_d, done_d;
  logic [7:0] mask_l;
  logic [DWELL_W-1:0] dwell_l, cnt, cnt_d;
  assign {a2, a1, a0} = addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      mask_l  <= '0;
      dwell_l <= '0;
      cont_l  <= 1'b0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      cnt   <= cnt_d;
      en    <= en_d;
      busy  <= busy_d;
      done  <= done_d;
      if (state == IDLE && start && !stop) begin
        mask_l  <= mask;
        dwell_l <= dwell;
        cont_l  <= cont;
      end
    end
  end
  // descending loops leave the lowest qualifying index in each result
  always_comb begin
    state_d = state;
    addr_d  = addr;
    cnt_d   = cnt;
    done_d  = 1'b0;
    nxt_idx = '0;
    nxt_ok  = 1'b0;
    low_in  = '0;
    low_l   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_l[i] && 3'(i) > addr) begin
        nxt_idx = 3'(i);
        nxt_ok  = 1'b1;
      end
      if (mask[i]) low_in = 3'(i);
      if (mask_l[i]) low_l = 3'(i);
    end
    if (state == IDLE) begin
      if (start && !stop) begin
        if (mask == 8'd0) done_d = 1'b1;
        else begin
          addr_d  = low_in;
          cnt_d   = dwell;
          state_d = FIRST;
        end
      end
    end else if (stop) state_d = IDLE;
    else if (state == BLANK) state_d = DRIVE;
    else if (cnt != '0) cnt_d = cnt - DWELL_W'(1);
    else if (nxt_ok || cont_l) begin
      addr_d  = nxt_ok ? nxt_idx : low_l;
      cnt_d   = dwell_l;
      state_d = FIRST;
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_comb begin
    en_d   = state_d == DRIVE;
    busy_d = state_d != IDLE;
  end
endmodule
